// File: rtl/ram_burst_master.sv
// ram_burst_master
//   Burst initiator for the single-port RAM valid/ready access interface.
//   Accepts a command (read/write, base word address, beat count) and issues
//   one RAM access per beat. Write beats are pulled from an upstream stream,
//   read beats are pushed downstream as one-cycle pulses.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   cmd_*             : burst command (valid/ready), wr/addr/len
//   wr_data*          : upstream write-data stream (valid/ready)
//   rd_data*          : downstream read-data pulses (no backpressure)
//   mem_*             : RAM access request / write data / read data / ack
//   busy, done, error : status; done/error are single-cycle pulses
module ram_burst_master #(
  parameter int W        = 8,
  parameter int D        = 16,
  parameter int ADDR_LEN = 4,
  parameter int TIMEOUT  = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_wr,
  input  logic [ADDR_LEN-1:0] cmd_addr,
  input  logic [ADDR_LEN:0]   cmd_len,
  input  logic [W-1:0]        wr_data,
  input  logic                wr_data_valid,
  output logic                wr_data_ready,
  output logic [W-1:0]        rd_data,
  output logic                rd_data_valid,
  output logic                mem_valid,
  output logic                mem_wrd,
  output logic [ADDR_LEN:0]   mem_address,
  output logic [W-1:0]        mem_wdata,
  input  logic [W-1:0]        mem_rdata,
  input  logic                mem_ready,
  output logic                busy,
  output logic                done,
  output logic                error
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_LEN:0] LEN_MAX = (ADDR_LEN + 1)'(D);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic                op_q, op_d;
  logic [ADDR_LEN-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_LEN:0]   beat_cnt_q, beat_cnt_d;
  logic [TW-1:0]       tmo_cnt_q, tmo_cnt_d;
  logic                mem_wrd_q, mem_wrd_d;
  logic [ADDR_LEN:0]   mem_address_q, mem_address_d;
  logic [W-1:0]        mem_wdata_q, mem_wdata_d;
  logic [W-1:0]        rd_data_q, rd_data_d;
  logic                rd_data_valid_q, rd_data_valid_d;
  logic                error_q, error_d;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      op_q            <= 1'b0;
      cur_addr_q      <= '0;
      beat_cnt_q      <= '0;
      tmo_cnt_q       <= '0;
      mem_wrd_q       <= 1'b0;
      mem_address_q   <= '0;
      mem_wdata_q     <= '0;
      rd_data_q       <= '0;
      rd_data_valid_q <= 1'b0;
      error_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      op_q            <= op_d;
      cur_addr_q      <= cur_addr_d;
      beat_cnt_q      <= beat_cnt_d;
      tmo_cnt_q       <= tmo_cnt_d;
      mem_wrd_q       <= mem_wrd_d;
      mem_address_q   <= mem_address_d;
      mem_wdata_q     <= mem_wdata_d;
      rd_data_q       <= rd_data_d;
      rd_data_valid_q <= rd_data_valid_d;
      error_q         <= error_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d         = state_q;
    op_d            = op_q;
    cur_addr_d      = cur_addr_q;
    beat_cnt_d      = beat_cnt_q;
    tmo_cnt_d       = tmo_cnt_q;
    mem_wrd_d       = mem_wrd_q;
    mem_address_d   = mem_address_q;
    mem_wdata_d     = mem_wdata_q;
    rd_data_d       = rd_data_q;
    rd_data_valid_d = 1'b0;
    error_d         = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          op_d       = cmd_wr;
          cur_addr_d = cmd_addr;
          beat_cnt_d = cmd_len;
          if (cmd_len == '0 || cmd_len > LEN_MAX) begin
            error_d = 1'b1;
          end else begin
            state_d = cmd_wr ? S_FETCH : S_ISSUE;
          end
        end
      end
      S_FETCH: begin
        if (wr_data_valid) begin
          mem_wdata_d = wr_data;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        tmo_cnt_d = '0;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (mem_ready) begin
          if (!op_q) begin
            rd_data_d       = mem_rdata;
            rd_data_valid_d = 1'b1;
          end
          // D is a power of two, so the natural wrap of cur_addr is modulo D
          cur_addr_d = cur_addr_q + ADDR_LEN'(1);
          beat_cnt_d = beat_cnt_q - (ADDR_LEN + 1)'(1);
          if (beat_cnt_q == (ADDR_LEN + 1)'(1)) begin
            state_d = S_DONE;
          end else begin
            state_d = op_q ? S_FETCH : S_ISSUE;
          end
        end else if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
          tmo_cnt_d = '0;
          error_d   = 1'b1;
          state_d   = S_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Address/op are loaded only when entering ISSUE so they hold their
    // last issued values while mem_valid is low.
    if (state_d == S_ISSUE) begin
      mem_address_d = {1'b0, cur_addr_d};
      mem_wrd_d     = op_d;
    end
  end

  // Output decode
  always_comb begin
    cmd_ready     = (state_q == S_IDLE) && !rst;
    wr_data_ready = (state_q == S_FETCH);
    busy          = (state_q != S_IDLE);
    mem_valid     = (state_q == S_ISSUE);
    done          = (state_q == S_DONE);
    mem_wrd       = mem_wrd_q;
    mem_address   = mem_address_q;
    mem_wdata     = mem_wdata_q;
    rd_data       = rd_data_q;
    rd_data_valid = rd_data_valid_q;
    error         = error_q;
  end

endmodule

// File: tb/tb_ram_burst_master.sv
// Testbench for ram_burst_master: table of directed bursts, hand-written
// timeout and mid-burst reset sequences, then randomized bursts, all checked
// against a queue/array reference model of the burst rules.
module tb_ram_burst_master;
  localparam int W   = 8;
  localparam int D   = 16;
  localparam int AL  = 4;
  localparam int TMO = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_wr;
  logic [AL-1:0] cmd_addr;
  logic [AL:0]   cmd_len;
  logic [W-1:0]  wr_data;
  logic          wr_data_valid, wr_data_ready;
  logic [W-1:0]  rd_data;
  logic          rd_data_valid;
  logic          mem_valid, mem_wrd;
  logic [AL:0]   mem_address;
  logic [W-1:0]  mem_wdata, mem_rdata;
  logic          mem_ready;
  logic          busy, done, error;

  always #5 clk = ~clk;

  ram_burst_master #(.W(W), .D(D), .ADDR_LEN(AL), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_data_valid(wr_data_valid), .wr_data_ready(wr_data_ready),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid),
    .mem_valid(mem_valid), .mem_wrd(mem_wrd), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy), .done(done), .error(error)
  );

  typedef struct {logic wrd; logic [AL:0] addr; logic [W-1:0] wdata; int cyc;} acc_t;
  typedef struct {logic [W-1:0] data; int cyc;} rd_t;
  typedef struct {
    bit wr; int addr; int len; int lat; int dbase;
    int exp_acc; bit exp_err; int exp_lat;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  acc_t         acc_q[$];
  rd_t          rd_q[$];
  int           done_q[$];
  int           err_q[$];
  logic [W-1:0] wq[$];
  logic [W-1:0] wd_exp[$];
  logic [W-1:0] ram[D];
  logic [W-1:0] model_mem[D];

  bit           pending, stuck, accepted;
  int           dly, lat_cfg, gap_pct, acc_cyc;
  logic [AL-1:0] p_addr;
  logic         end_busy, end_cmd_ready;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Finish the current cycle (record handshakes sampled at the next edge),
  // advance one clock, then observe outputs and drive the environment.
  task automatic tick();
    bit cmd_fire, wr_fire;
    cmd_fire = cmd_valid && cmd_ready;
    wr_fire  = wr_data_valid && wr_data_ready;
    if (cmd_fire) begin
      accepted = 1'b1;
      acc_cyc  = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (cmd_fire) cmd_valid = 1'b0;
    if (wr_fire) void'(wq.pop_front());

    if (mem_valid) acc_q.push_back('{mem_wrd, mem_address, mem_wdata, cyc});
    if (rd_data_valid) rd_q.push_back('{rd_data, cyc});
    if (done) done_q.push_back(cyc);
    if (error) err_q.push_back(cyc);
    chk("cmd_ready_decode", cmd_ready, (!busy && !rst));
    if (mem_valid) chk("addr_msb_zero", mem_address[AL], 0);

    // RAM responder: accept request in ISSUE, acknowledge lat_cfg cycles into WAIT
    if (rst) begin
      pending   = 1'b0;
      mem_ready = 1'b0;
    end else if (mem_valid) begin
      pending   = 1'b1;
      dly       = lat_cfg;
      p_addr    = mem_address[AL-1:0];
      if (mem_wrd) ram[p_addr] = mem_wdata;
      mem_ready = 1'b0;
    end else if (pending) begin
      if (dly == 0 && !stuck) begin
        mem_ready = 1'b1;
        mem_rdata = ram[p_addr];
        pending   = 1'b0;
      end else begin
        mem_ready = 1'b0;
        if (dly > 0) dly--;
      end
    end else begin
      mem_ready = 1'b0;
    end

    if (wq.size() > 0 && $urandom_range(0, 99) >= gap_pct) begin
      wr_data_valid = 1'b1;
      wr_data       = wq[0];
    end else begin
      wr_data_valid = 1'b0;
    end
  endtask

  task automatic run_cmd(input bit wr, input int addr, input int len,
                         input int dbase, input int budget);
    int n;
    bit legal;
    logic [W-1:0] d;
    legal = (len >= 1) && (len <= D);
    acc_q.delete(); rd_q.delete(); done_q.delete(); err_q.delete();
    wq.delete(); wd_exp.delete();
    accepted = 1'b0;
    if (wr && legal) begin
      for (int i = 0; i < len; i++) begin
        d = (dbase >= 0) ? W'(dbase + i + 1) : W'($urandom);
        wd_exp.push_back(d);
        wq.push_back(d);
      end
    end
    cmd_wr    = wr;
    cmd_addr  = AL'(addr);
    cmd_len   = (AL + 1)'(len);
    cmd_valid = 1'b1;
    n = 0;
    while (!(accepted && (done_q.size() + err_q.size() > 0)) && n < budget) begin
      tick();
      n++;
    end
    end_busy      = busy;
    end_cmd_ready = cmd_ready;
    chk("burst_end_within_budget", (n < budget), 1);
    cmd_valid = 1'b0;
    repeat (3) tick();
  endtask

  task automatic check_burst(input bit wr, input int addr, input int len, input int lat,
                             input int exp_acc, input bit exp_err, input int exp_lat);
    int ea;
    chk("cmd_accepted", accepted, 1);
    chk("n_access", acc_q.size(), exp_acc);
    chk("n_error", err_q.size(), exp_err);
    chk("n_done", done_q.size(), exp_err ? 0 : 1);
    if (exp_err) begin
      chk("n_rd_on_error", rd_q.size(), 0);
      if (err_q.size() > 0) chk("error_latency", err_q[0] - acc_cyc, exp_lat);
    end else begin
      for (int i = 0; i < acc_q.size() && i < len; i++) begin
        ea = (addr + i) % D;
        chk("acc_addr", acc_q[i].addr, ea);
        chk("acc_wrd", acc_q[i].wrd, wr);
        if (wr) chk("acc_wdata", acc_q[i].wdata, wd_exp[i]);
        if (i > 0 && (!wr || gap_pct == 0))
          chk("beat_spacing", acc_q[i].cyc - acc_q[i-1].cyc, (wr ? 3 : 2) + lat);
      end
      if (!wr) begin
        chk("n_rd", rd_q.size(), len);
        for (int i = 0; i < rd_q.size() && i < len; i++) begin
          chk("rd_data", rd_q[i].data, model_mem[(addr + i) % D]);
          if (i < acc_q.size()) chk("rd_timing", rd_q[i].cyc - acc_q[i].cyc, lat + 2);
        end
      end else begin
        chk("n_rd_on_write", rd_q.size(), 0);
        for (int i = 0; i < len; i++) model_mem[(addr + i) % D] = wd_exp[i];
      end
      if (done_q.size() > 0) begin
        if (exp_lat >= 0) chk("done_latency", done_q[0] - acc_cyc, exp_lat);
        if (acc_q.size() > 0)
          chk("done_after_last_beat", done_q[0] - acc_q[acc_q.size()-1].cyc, lat + 2);
      end
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_mem_valid"}, mem_valid, 0);
    chk({tag, "_mem_wrd"}, mem_wrd, 0);
    chk({tag, "_mem_address"}, mem_address, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_rd_data"}, rd_data, 0);
    chk({tag, "_rd_data_valid"}, rd_data_valid, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_wr_data_ready"}, wr_data_ready, 0);
    chk({tag, "_cmd_ready"}, cmd_ready, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    int n, wr, addr, len, lat, exp_lat;
    bit legal;

    rst = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_data = '0; wr_data_valid = 1'b0; mem_rdata = '0; mem_ready = 1'b0;
    pending = 1'b0; stuck = 1'b0; accepted = 1'b0; dly = 0;
    lat_cfg = 0; gap_pct = 0; acc_cyc = 0; p_addr = '0;
    for (int i = 0; i < D; i++) begin
      ram[i]       = W'($urandom);
      model_mem[i] = ram[i];
    end

    // Reset state
    repeat (2) tick();
    check_zero("reset");
    rst = 1'b0;
    tick();
    chk("cmd_ready_after_reset", cmd_ready, 1);

    // wr, addr, len, lat, dbase, exp_acc, exp_err, exp_lat
    vecs.push_back('{1,  3,  4, 0, 'hA0,  4, 0, 13});
    vecs.push_back('{0,  3,  4, 0,   -1,  4, 0,  9});
    vecs.push_back('{1, 14,  4, 0, 'hB0,  4, 0, 13});
    vecs.push_back('{0, 14,  4, 0,   -1,  4, 0,  9});
    vecs.push_back('{1,  0,  0, 0, 'hC0,  0, 1,  1});
    vecs.push_back('{0,  0, 17, 0,   -1,  0, 1,  1});
    vecs.push_back('{0,  0, 16, 0,   -1, 16, 0, 33});
    vecs.push_back('{0,  5,  1, 2,   -1,  1, 0,  5});
    vecs.push_back('{1, 15,  1, 1, 'hD0,  1, 0,  5});
    vecs.push_back('{1,  9, 16, 0, 'h40, 16, 0, 49});
    vecs.push_back('{0,  9, 16, 1,   -1, 16, 0, 49});

    gap_pct = 0;
    foreach (vecs[k]) begin
      lat_cfg = vecs[k].lat;
      run_cmd(vecs[k].wr, vecs[k].addr, vecs[k].len, vecs[k].dbase, 200);
      check_burst(vecs[k].wr, vecs[k].addr, vecs[k].len, vecs[k].lat,
                  vecs[k].exp_acc, vecs[k].exp_err, vecs[k].exp_lat);
    end

    // Timeout: RAM never acknowledges
    stuck = 1'b1; lat_cfg = 0;
    run_cmd(0, 2, 2, -1, 80);
    chk("tmo_n_access", acc_q.size(), 1);
    chk("tmo_n_error", err_q.size(), 1);
    if (err_q.size() > 0) chk("tmo_error_latency", err_q[0] - acc_cyc, TMO + 2);
    chk("tmo_n_rd", rd_q.size(), 0);
    chk("tmo_n_done", done_q.size(), 0);
    chk("tmo_busy_at_error", end_busy, 0);
    chk("tmo_cmd_ready_at_error", end_cmd_ready, 1);
    stuck = 1'b0; pending = 1'b0;
    tick();

    // Reset during the WAIT of beat 2 of a 4-beat read
    acc_q.delete(); rd_q.delete(); done_q.delete(); err_q.delete();
    accepted = 1'b0;
    cmd_wr = 1'b0; cmd_addr = AL'(6); cmd_len = (AL + 1)'(4); cmd_valid = 1'b1;
    n = 0;
    while (acc_q.size() < 2 && n < 50) begin
      tick();
      n++;
    end
    chk("mid_burst_second_issue", acc_q.size(), 2);
    tick();
    chk("mid_burst_in_wait_busy", busy, 1);
    chk("mid_burst_in_wait_valid", mem_valid, 0);
    rst = 1'b1;
    tick();
    check_zero("midrst");
    rst = 1'b0;
    tick();
    chk("midrst_cmd_ready_after", cmd_ready, 1);
    chk("midrst_no_done", done_q.size(), 0);
    chk("midrst_rd_beats", rd_q.size(), 1);
    run_cmd(0, 6, 4, -1, 100);
    check_burst(0, 6, 4, 0, 4, 0, 9);

    // Randomized bursts
    for (int it = 0; it < 40; it++) begin
      wr      = $urandom_range(0, 1);
      addr    = $urandom_range(0, D - 1);
      len     = $urandom_range(0, D + 1);
      lat     = $urandom_range(0, 2);
      lat_cfg = lat;
      gap_pct = (wr != 0 && $urandom_range(0, 1) != 0) ? $urandom_range(10, 60) : 0;
      legal   = (len >= 1) && (len <= D);
      if (!legal)            exp_lat = 1;
      else if (wr == 0)      exp_lat = len * (2 + lat) + 1;
      else if (gap_pct == 0) exp_lat = len * (3 + lat) + 1;
      else                   exp_lat = -1;
      run_cmd(wr[0], addr, len, -1, 600);
      check_burst(wr[0], addr, len, lat, legal ? len : 0, !legal, exp_lat);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
